// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one add-and-shift step per clock through a chain of 4-bit ripple adders.
// Optional build macro MUL_ZERO_SKIP_EN: a zero operand bypasses RUN and reports P=0 one cycle after the start sample.

module parallel_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[4];

endmodule

module shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   P
);

   // state  | meaning
   // IDLE   | waiting for start; P holds the last product
   // RUN    | one add-and-shift step per cycle, WIDTH steps
   // DONE   | product transferred to P, done pulses on the next cycle
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int NSLICE = WIDTH / 4;
   localparam int CW     = $clog2(WIDTH) + 1;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [WIDTH-1:0]     h_q, h_d;
   logic                 c_q, c_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [2*WIDTH-1:0]   p_q, p_d;

   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic [NSLICE:0]      carry;
   logic                 cout;

   assign addend   = q_q[0] ? m_q : '0;
   assign carry[0] = 1'b0;

   for (genvar g = 0; g < NSLICE; g++) begin : g_slice
      parallel_adder u_add (
         .a    (h_q[4*g +: 4]),
         .b    (addend[4*g +: 4]),
         .cin  (carry[g]),
         .sum  (sum[4*g +: 4]),
         .cout (carry[g+1])
      );
   end

   assign cout = carry[NSLICE];

   // C keeps the carry of the latest step for observation; the same bit is already folded into H's MSB.
   logic carry_unused;
   assign carry_unused = c_q;

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      h_d     = h_q;
      c_d     = c_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      p_d     = p_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d   = A;
               q_d   = B;
               h_d   = '0;
               c_d   = 1'b0;
               cnt_d = '0;
`ifdef MUL_ZERO_SKIP_EN
               if (A == '0 || B == '0) begin
                  q_d     = '0;
                  state_d = S_DONE;
               end else begin
                  busy_d  = 1'b1;
                  state_d = S_RUN;
               end
`else
               busy_d  = 1'b1;
               state_d = S_RUN;
`endif
            end
         end

         S_RUN: begin
            // {C,H,Q} <= {cout,sum,Q} >> 1 with cout landing in H's MSB
            c_d   = cout;
            h_d   = {cout, sum[WIDTH-1:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               busy_d  = 1'b0;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            p_d     = {h_q, q_q};
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         h_q     <= '0;
         c_q     <= 1'b0;
         q_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         h_q     <= h_d;
         c_q     <= c_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         p_q     <= p_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign P    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: WIDTH=4 and WIDTH=8 instances against an arithmetic reference.
// Expectations for zero operands follow MUL_ZERO_SKIP_EN when the bench is built with it.

module tb_shift_add_multiplier;

   localparam int W  = 4;
   localparam int W8 = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [W-1:0]      a, b;
   logic              busy, done;
   logic [2*W-1:0]    p;

   logic              start8;
   logic [W8-1:0]     a8, b8;
   logic              busy8, done8;
   logic [2*W8-1:0]   p8;

   int total = 0;
   int bad   = 0;

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
      .busy(busy), .done(done), .P(p)
   );

   shift_add_multiplier #(.WIDTH(W8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .P(p8)
   );

   always #5 clk = ~clk;

   function automatic int exp_lat(int w, int x, int y);
`ifdef MUL_ZERO_SKIP_EN
      if (x == 0 || y == 0) return 1;
`endif
      return w + 1;
   endfunction

   function automatic int exp_busy(int w, int x, int y);
`ifdef MUL_ZERO_SKIP_EN
      if (x == 0 || y == 0) return 0;
`endif
      return w;
   endfunction

   // Caller is at a negedge. Returns at the negedge where done is seen (lat = cycles after start sample, -1 on timeout).
   task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         output int lat, output int bcnt, output int pres, output int overlap);
      start = 1'b1; a = ai; b = bi;
      lat = -1; bcnt = 0; overlap = 0; pres = -1;
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < 40; j++) begin
         if (j > 0) @(negedge clk);
         if (busy) bcnt++;
         if (busy && done) overlap++;
         if (done) begin
            lat  = j;
            pres = int'(p);
            break;
         end
      end
   endtask

   task automatic run_op8(input logic [W8-1:0] ai, input logic [W8-1:0] bi,
                          output int lat, output int bcnt, output int pres);
      start8 = 1'b1; a8 = ai; b8 = bi;
      lat = -1; bcnt = 0; pres = -1;
      @(negedge clk);
      start8 = 1'b0;
      for (int j = 0; j < 60; j++) begin
         if (j > 0) @(negedge clk);
         if (busy8) bcnt++;
         if (done8) begin
            lat  = j;
            pres = int'(p8);
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      #2;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (p !== '0) begin bad++; $display("FAIL reset_p got=%h want=00", p); end
      total++; if (p8 !== '0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
         bad++; $display("FAIL reset_w8 got p=%h busy=%b done=%b want all 0", p8, busy8, done8);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_directed;
      int ta [5] = '{15, 10, 1, 0, 15};
      int tb [5] = '{15, 12, 1, 7, 0};
      int lat, bcnt, pres, ov, want;
      for (int i = 0; i < 5; i++) begin
         run_op(W'(ta[i]), W'(tb[i]), lat, bcnt, pres, ov);
         want = ta[i] * tb[i];
         total++; if (pres !== want) begin bad++; $display("FAIL dir_p a=%0d b=%0d got=%0d want=%0d", ta[i], tb[i], pres, want); end
         total++; if (lat !== exp_lat(W, ta[i], tb[i])) begin bad++; $display("FAIL dir_lat a=%0d b=%0d got=%0d want=%0d", ta[i], tb[i], lat, exp_lat(W, ta[i], tb[i])); end
         total++; if (bcnt !== exp_busy(W, ta[i], tb[i])) begin bad++; $display("FAIL dir_busy a=%0d b=%0d got=%0d want=%0d", ta[i], tb[i], bcnt, exp_busy(W, ta[i], tb[i])); end
         total++; if (ov !== 0) begin bad++; $display("FAIL dir_overlap got=%0d want=0", ov); end
         repeat (3) begin
            @(negedge clk);
            total++; if (int'(p) !== want || done !== 1'b0) begin
               bad++; $display("FAIL dir_hold got p=%0d done=%b want p=%0d done=0", p, done, want);
            end
         end
      end
   endtask

   task automatic test_exhaustive;
      int lat, bcnt, pres, ov;
      logic [7:0] v;
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         v = 8'(i);
         run_op(v[7:4], v[3:0], lat, bcnt, pres, ov);
         total++; if (pres !== int'(v[7:4]) * int'(v[3:0]) || lat !== exp_lat(W, int'(v[7:4]), int'(v[3:0]))) begin
            bad++; $display("FAIL sweep a=%0d b=%0d got p=%0d lat=%0d want p=%0d lat=%0d",
                            v[7:4], v[3:0], pres, lat, int'(v[7:4]) * int'(v[3:0]), exp_lat(W, int'(v[7:4]), int'(v[3:0])));
         end
      end
   endtask

   task automatic test_random;
      int lat, bcnt, pres, ov, x, y;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         x = int'($urandom_range(15, 0));
         y = int'($urandom_range(15, 0));
         run_op(W'(x), W'(y), lat, bcnt, pres, ov);
         total++; if (pres !== x * y || bcnt !== exp_busy(W, x, y) || ov !== 0) begin
            bad++; $display("FAIL rand a=%0d b=%0d got p=%0d busy=%0d ov=%0d want p=%0d busy=%0d ov=0",
                            x, y, pres, bcnt, ov, x * y, exp_busy(W, x, y));
         end
         repeat ($urandom_range(3, 0)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      int lat1, lat2, bcnt, p1, p2, ov;
      repeat (2) @(negedge clk);
      run_op(4'd7, 4'd9, lat1, bcnt, p1, ov);
      run_op(4'd11, 4'd13, lat2, bcnt, p2, ov);
      total++; if (p1 !== 63 || p2 !== 143) begin bad++; $display("FAIL b2b_p got=%0d,%0d want=63,143", p1, p2); end
      total++; if (lat2 !== W + 1) begin bad++; $display("FAIL b2b_lat got=%0d want=%0d", lat2, W + 1); end
   endtask

   task automatic test_start_ignored;
      int ndone, pres, first;
      repeat (2) @(negedge clk);
      start = 1'b1; a = 4'd3; b = 4'd5;
      ndone = 0; pres = -1; first = -1;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         start = 1'b0;
         if (j == 1 || j == W) begin start = 1'b1; a = 4'd9; b = 4'd9; end
         if (done) begin
            ndone++;
            if (first < 0) begin first = j; pres = int'(p); end
         end
      end
      start = 1'b0;
      total++; if (ndone !== 1) begin bad++; $display("FAIL ign_count got=%0d want=1", ndone); end
      total++; if (pres !== 15) begin bad++; $display("FAIL ign_p got=%0d want=15", pres); end
      total++; if (first !== W + 1) begin bad++; $display("FAIL ign_lat got=%0d want=%0d", first, W + 1); end
   endtask

   task automatic test_reset_midrun;
      int ndone, nbusy, lat, bcnt, pres, ov;
      repeat (2) @(negedge clk);
      start = 1'b1; a = 4'd15; b = 4'd15;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
         bad++; $display("FAIL rst_mid got busy=%b done=%b p=%h want 0 0 00", busy, done, p);
      end
      @(negedge clk);
      rst = 1'b0;
      ndone = 0; nbusy = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) nbusy++;
      end
      total++; if (ndone !== 0 || nbusy !== 0) begin bad++; $display("FAIL rst_abandon got done=%0d busy=%0d want 0 0", ndone, nbusy); end
      run_op(4'd6, 4'd7, lat, bcnt, pres, ov);
      total++; if (pres !== 42 || lat !== W + 1) begin bad++; $display("FAIL rst_after got p=%0d lat=%0d want p=42 lat=%0d", pres, lat, W + 1); end
   endtask

   task automatic test_width8;
      int lat, bcnt, pres, x, y;
      repeat (2) @(negedge clk);
      run_op8(8'd255, 8'd255, lat, bcnt, pres);
      total++; if (pres !== 32'hFE01) begin bad++; $display("FAIL w8_max got=%h want=fe01", pres); end
      total++; if (lat !== W8 + 1 || bcnt !== W8) begin bad++; $display("FAIL w8_timing got lat=%0d busy=%0d want lat=%0d busy=%0d", lat, bcnt, W8 + 1, W8); end
      for (int i = 0; i < 12; i++) begin
         x = (i == 0) ? 0 : int'($urandom_range(255, 0));
         y = int'($urandom_range(255, 1));
         run_op8(8'(x), 8'(y), lat, bcnt, pres);
         total++; if (pres !== x * y || lat !== exp_lat(W8, x, y)) begin
            bad++; $display("FAIL w8_rand a=%0d b=%0d got p=%0d lat=%0d want p=%0d lat=%0d", x, y, pres, lat, x * y, exp_lat(W8, x, y));
         end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_exhaustive;
      test_random;
      test_back_to_back;
      test_start_ignored;
      test_reset_midrun;
      test_width8;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
